// File: rtl/md_pkg.sv
// md_pkg: shared opcode and FSM encodings for the multiply/divide unit
package md_pkg;

   typedef enum logic [3:0] {
      MD_NONE = 4'd0,
      MULT    = 4'd1,
      MULTU   = 4'd2,
      DIV     = 4'd3,
      DIVU    = 4'd4,
      MTHI    = 4'd5,
      MTLO    = 4'd6
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic is_md_op(input logic [3:0] op);
      return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
   endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle HI/LO multiply-divide unit with hazard stall request
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        wr_q, wr_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

   logic        is_md, is_div, dz, ovf;
   logic [31:0] dvs_s, dvs_u, quo_s, rem_s, res_hi, res_lo;
   logic [63:0] prod_s, prod_u;

   assign is_md  = is_md_op(md_op);
   assign is_div = (md_op == DIV) || (md_op == DIVU);
   assign dz     = (b == 32'd0);
   assign ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   // divisors are forced to 1 where the quotient is overridden, so the operators never see /0 or overflow
   assign dvs_s  = (dz || ovf) ? 32'd1 : b;
   assign dvs_u  = dz ? 32'd1 : b;
   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'd0, a} * {32'd0, b};
   assign quo_s  = $signed(a) / $signed(dvs_s);
   assign rem_s  = $signed(a) % $signed(dvs_s);
   assign res_hi = (md_op == MULT)  ? prod_s[63:32] :
                   (md_op == MULTU) ? prod_u[63:32] :
                   (md_op == DIV)   ? (ovf ? 32'd0 : rem_s) : a % dvs_u;
   assign res_lo = (md_op == MULT)  ? prod_s[31:0] :
                   (md_op == MULTU) ? prod_u[31:0] :
                   (md_op == DIV)   ? (ovf ? 32'h8000_0000 : quo_s) : a / dvs_u;

   assign stall_req = busy_q | (start & is_md);
   assign busy      = busy_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

   // next-state: accept work in IDLE, count down in RUN and commit the shadow result at cnt = 0
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      wr_d    = wr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sh_hi_d = sh_hi_q;
      sh_lo_d = sh_lo_q;
      if (state_q == IDLE) begin
         if (start && is_md) begin
            sh_hi_d = res_hi;
            sh_lo_d = res_lo;
            wr_d    = !(is_div && dz);
            cnt_d   = is_div ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
            busy_d  = 1'b1;
            state_d = RUN;
         end else if (start && md_op == MTHI) begin
            hi_d = a;
         end else if (start && md_op == MTLO) begin
            lo_d = a;
         end
      end else if (cnt_q == 4'd0) begin
         hi_d    = wr_q ? sh_hi_q : hi_q;
         lo_d    = wr_q ? sh_lo_q : lo_q;
         busy_d  = 1'b0;
         state_d = IDLE;
      end else begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   // state registers, cleared asynchronously so a reset mid-operation discards the pending result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         wr_q    <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         sh_hi_q <= 32'd0;
         sh_lo_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         wr_q    <= wr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sh_hi_q <= sh_hi_d;
         sh_lo_q <= sh_lo_d;
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: vector table, corner sequences and randomized checks for md_unit
module tb_md_unit;
   import md_pkg::*;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [3:0]  md_op = 4'd0;
   logic [31:0] a = 32'd0, b = 32'd0;
   logic        busy, stall_req;
   logic [31:0] hi, lo;
   int          checks = 0, errors = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] x, y, eh, el;
   } vec_t;

   md_unit dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
      .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int lat(input logic [3:0] op);
      return (op == 4'd1 || op == 4'd2) ? 5 : (op == 4'd3 || op == 4'd4) ? 10 : 0;
   endfunction

   // architectural effect of one accepted operation, from the arithmetic rules
   task automatic ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      longint p;
      int xi, yi;
      xi = x;
      yi = y;
      case (op)
         4'd1: begin p = longint'(xi) * longint'(yi); {m_hi, m_lo} = p; end
         4'd2: begin p = longint'({32'd0, x}) * longint'({32'd0, y}); {m_hi, m_lo} = p; end
         4'd3: if (y != 0) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               m_lo = 32'h8000_0000;
               m_hi = 32'd0;
            end else begin
               m_lo = xi / yi;
               m_hi = xi % yi;
            end
         end
         4'd4: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
         4'd5: m_hi = x;
         4'd6: m_lo = x;
         default: ;
      endcase
   endtask

   task automatic wait_idle(input string nm, input logic [31:0] oh, input logic [31:0] ol, output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         chk({nm, " hi held"}, hi, oh);
         chk({nm, " lo held"}, lo, ol);
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      int cnt;
      logic [31:0] oh, ol;
      oh = m_hi;
      ol = m_lo;
      @(negedge clk);
      start = 1'b1; md_op = op; a = x; b = y;
      #1;
      chk({nm, " stall_req"}, 32'(stall_req), 32'(lat(op) != 0));
      @(posedge clk); #1;
      start = 1'b0; md_op = 4'd0;
      wait_idle(nm, oh, ol, cnt);
      chk({nm, " busy cycles"}, cnt, lat(op));
      ref_op(op, x, y);
      chk({nm, " hi"}, hi, m_hi);
      chk({nm, " lo"}, lo, m_lo);
   endtask

   initial begin
      vec_t vt[13];
      int cnt;
      logic [3:0] op;
      logic [31:0] x, y;
      vt[0]  = '{4'd1, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vt[1]  = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vt[2]  = '{4'd4, 32'd100,       32'd7,          32'd2,         32'd14};
      vt[3]  = '{4'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vt[4]  = '{4'd3, 32'd55,        32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vt[5]  = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
      vt[6]  = '{4'd1, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
      vt[7]  = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vt[8]  = '{4'd4, 32'hFFFF_FFFF, 32'd10,         32'd5,         32'h1999_9999};
      vt[9]  = '{4'd5, 32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 32'h1999_9999};
      vt[10] = '{4'd6, 32'h0000_1234, 32'd0,          32'hDEAD_BEEF, 32'h0000_1234};
      vt[11] = '{4'd7, 32'd5,         32'd9,          32'hDEAD_BEEF, 32'h0000_1234};
      vt[12] = '{4'd4, 32'd5,         32'd0,          32'hDEAD_BEEF, 32'h0000_1234};

      #2;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      @(negedge clk); reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         do_op($sformatf("vec%0d", i), vt[i].op, vt[i].x, vt[i].y);
         chk($sformatf("vec%0d table hi", i), hi, vt[i].eh);
         chk($sformatf("vec%0d table lo", i), lo, vt[i].el);
      end

      // MTLO offered while busy is dropped; the multiply result still lands
      @(negedge clk); start = 1'b1; md_op = 4'd1; a = 32'd3; b = 32'd4;
      @(posedge clk); #1;
      md_op = 4'd6; a = 32'h0000_1234;
      #1 chk("mtlo busy stall_req", 32'(stall_req), 32'd1);
      @(posedge clk); #1;
      start = 1'b0; md_op = 4'd0;
      wait_idle("mult3x4", m_hi, m_lo, cnt);
      chk("mult3x4 busy cycles", cnt, 4);
      chk("mtlo ignored lo", lo, 32'd12);
      chk("mtlo ignored hi", hi, 32'd0);
      m_hi = 32'd0; m_lo = 32'd12;
      do_op("mtlo idle", 4'd6, 32'h0000_1234, 32'd0);
      chk("mtlo idle lo", lo, 32'h0000_1234);

      // back-to-back MULTs with start held: second accepted the cycle after busy falls
      @(negedge clk); start = 1'b1; md_op = 4'd1; a = 32'd2; b = 32'd3;
      #1 chk("b2b stall 0", 32'(stall_req), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) begin a = 32'd5; b = 32'hFFFF_FFFC; end
         #1 chk($sformatf("b2b stall %0d", i + 1), 32'(stall_req), 32'd1);
      end
      chk("b2b first hi", hi, 32'd0);
      chk("b2b first lo", lo, 32'd6);
      chk("b2b gap busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      start = 1'b0; md_op = 4'd0;
      wait_idle("b2b second", 32'd0, 32'd6, cnt);
      chk("b2b second busy cycles", cnt, 5);
      chk("b2b second hi", hi, 32'hFFFF_FFFF);
      chk("b2b second lo", lo, 32'hFFFF_FFEC);
      m_hi = hi; m_lo = lo;

      // reset in the middle of a divide: everything clears at once and nothing commits later
      do_op("mthi pre", 4'd5, 32'h55, 32'd0);
      @(negedge clk); start = 1'b1; md_op = 4'd4; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; md_op = 4'd0;
      repeat (6) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort hi", hi, 32'd0);
      chk("abort lo", lo, 32'd0);
      @(negedge clk); reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("post abort busy", 32'(busy), 32'd0);
      chk("post abort hi", hi, 32'd0);
      chk("post abort lo", lo, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0;

      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 7));
         x = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 4))
            0: y = 32'd0;
            1: y = 32'hFFFF_FFFF;
            2: y = 32'($urandom_range(1, 20));
            default: y = $urandom;
         endcase
         do_op($sformatf("rand%0d op%0d", i, op), op, x, y);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: cycles busy is held for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: cycles busy is held for DIV/DIVU.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  EX-stage request; qualifies md_op, a and b for one cycle.
REQ-006 md_op  in  4  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes are no-op.
REQ-007 a  in  32  operand rs (multiplicand or dividend; source for MTHI/MTLO).
REQ-008 b  in  32  operand rt (multiplier or divisor).
REQ-009 busy  out  1  registered; high while an operation is in flight.
REQ-010 stall_req  out  1  combinational; busy OR (start AND md_op is MULT/MULTU/DIV/DIVU); drives the hazard unit that stalls ID/EX.
REQ-011 hi  out  32  HI register.
REQ-012 lo  out  32  LO register.

Function
REQ-013 FSM states: IDLE, RUN; 4-bit down-counter cnt.
REQ-014 IDLE with start and a mult/div op: latch the result into shadow regs, load cnt = cycles-1, go to RUN; busy = 1 from the next edge.
REQ-015 RUN: cnt decrements each edge; at the edge where cnt = 0, commit shadow to hi/lo, clear busy, return to IDLE.
REQ-016 Latency: start sampled at edge k gives busy high over edges k+1 to k+N and new hi/lo visible after edge k+N (N = MULT_CYCLES or DIV_CYCLES).
REQ-017 hi/lo hold their old values throughout RUN; a partial result is never visible.
REQ-018 MULT: {hi,lo} = signed 32x32 to 64-bit product. MULTU: same, unsigned.
REQ-019 DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend. DIVU: unsigned.
REQ-020 Divide by zero: the operation still takes DIV_CYCLES, busy behaves as normal, and hi/lo remain unchanged.
REQ-021 DIV with 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-022 MTHI/MTLO in IDLE: hi (or lo) <= a at the next edge; busy stays 0.
REQ-023 While busy = 1, any start is ignored, including MTHI/MTLO; upstream guarantees this via stall_req.
REQ-024 Undefined md_op with start: no state change.
REQ-025 Back-to-back: start in the same cycle that busy falls is ignored, because busy is still 1; start is accepted on the following cycle.

Reset
REQ-026 On reset assertion, immediately (asynchronous): state = IDLE, cnt = 0, busy = 0, hi = 0, lo = 0, shadow = 0.
REQ-027 Reset during RUN aborts the operation; no commit occurs after release.
REQ-028 First start after reset release is accepted on the first posedge with reset low.

Structure
REQ-029 Shared package md_pkg holds md_op encodings (MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6) and the FSM state encoding.
REQ-030 Arithmetic is behavioural (operators) inside md_unit, computed at start; no sub-module.
REQ-031 stall_req is the only combinational output; busy, hi and lo come straight from flops.

Verification
REQ-032 MULT a=0xFFFFFFFE (-2), b=3: busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 DIVU a=100, b=7: busy high 10 cycles, hi/lo unchanged during RUN; then lo=14, hi=2.
REQ-034 DIV a=-7, b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV by 0: after 10 cycles hi/lo unchanged.
REQ-035 MTLO a=0x1234 while busy: ignored (lo unchanged after commit); MTLO in IDLE: lo=0x1234 next cycle, busy never rises.
REQ-036 Reset asserted mid-RUN at cnt=3: busy, hi and lo all 0 immediately; no commit after release.
REQ-037 Two MULTs issued as soon as busy=0: stall_req high continuously across both; second result correct 5 cycles after it is accepted.
